// File: rtl/alarm_ctrl_fsm_pkg.sv
// Shared types and constants for the anti-theft alarm sequencer.
package alarm_ctrl_fsm_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_ARMED        = 3'd0,
        ST_TRIGGERED    = 3'd1,
        ST_SOUND_OPEN   = 3'd2,
        ST_SOUND_CLOSED = 3'd3,
        ST_DISARMED     = 3'd4,
        ST_WAIT_OPEN    = 3'd5,
        ST_WAIT_CLOSE   = 3'd6,
        ST_ARM_DELAY    = 3'd7
    } state_e;

    localparam logic [SEL_W-1:0] SEL_ARM    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_DRIVER = 2'b01;
    localparam logic [SEL_W-1:0] SEL_PASS   = 2'b10;
    localparam logic [SEL_W-1:0] SEL_ALARM  = 2'b11;

    // States that own a running Timer interval and may consume its expiry.
    function automatic logic is_timed(input state_e s);
        return (s == ST_TRIGGERED) || (s == ST_SOUND_CLOSED) || (s == ST_ARM_DELAY);
    endfunction

endpackage

// File: rtl/alarm_ctrl_fsm_expiry_qual.sv
// Timer expiry qualifier: tracks an owned countdown and masks the expired level
// during the start pulse and the cycle after it, while the Timer is still reloading.
module alarm_ctrl_fsm_expiry_qual (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic clear_i,
    input  logic expired_i,
    output logic exp_c_o
);

    logic tmr_run_q;
    logic start_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_run_q    <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_prev_q <= start_i;
            if (start_i) begin
                tmr_run_q <= 1'b1;
            end else if (clear_i) begin
                tmr_run_q <= 1'b0;
            end
        end
    end

    assign exp_c_o = tmr_run_q & expired_i & ~start_i & ~start_prev_q;

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Anti-theft alarm sequencer: door/ignition driven FSM with Timer handshake and siren/LED control.
// Build option REARM_ABORT_EN: passenger door also aborts the arming delay.
module alarm_ctrl_fsm
    import alarm_ctrl_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ignition,
    input  logic               door_driver,
    input  logic               door_pass,
    input  logic               reprogram,
    input  logic               expired,
    input  logic               one_hz_enable,
    output logic [SEL_W-1:0]   interval,
    output logic               start_timer,
    output logic               enable_siren,
    output logic               status,
    output logic [STATE_W-1:0] state_code
);

    state_e             state_q;
    logic [SEL_W-1:0]   interval_q;
    logic               start_q;
    logic               siren_q;
    logic               status_q;
    logic               exp_c;
    logic               clear_c;
    logic               door_any_c;
    logic               rearm_block_c;

    assign door_any_c = door_driver | door_pass;
    assign clear_c    = ~is_timed(state_q);

`ifdef REARM_ABORT_EN
    assign rearm_block_c = door_driver | door_pass;
`else
    assign rearm_block_c = door_driver;
`endif

    alarm_ctrl_fsm_expiry_qual u_expiry_qual (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_q),
        .clear_i   (clear_c),
        .expired_i (expired),
        .exp_c_o   (exp_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARMED;
            interval_q <= SEL_ARM;
            start_q    <= 1'b0;
            siren_q    <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (reprogram) begin
                // Holding reprogram in ARMED keeps the blink running.
                state_q  <= ST_ARMED;
                siren_q  <= 1'b0;
                status_q <= (state_q == ST_ARMED) ? (status_q ^ one_hz_enable) : 1'b0;
            end else if (ignition) begin
                state_q  <= ST_DISARMED;
                siren_q  <= 1'b0;
                status_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (door_driver) begin
                            state_q    <= ST_TRIGGERED;
                            interval_q <= SEL_DRIVER;
                            start_q    <= 1'b1;
                            status_q   <= 1'b1;
                        end else if (door_pass) begin
                            state_q    <= ST_TRIGGERED;
                            interval_q <= SEL_PASS;
                            start_q    <= 1'b1;
                            status_q   <= 1'b1;
                        end else begin
                            status_q <= status_q ^ one_hz_enable;
                        end
                    end
                    ST_TRIGGERED: begin
                        if (exp_c) begin
                            siren_q <= 1'b1;
                            if (door_any_c) begin
                                state_q <= ST_SOUND_OPEN;
                            end else begin
                                state_q    <= ST_SOUND_CLOSED;
                                interval_q <= SEL_ALARM;
                                start_q    <= 1'b1;
                            end
                        end
                    end
                    ST_SOUND_OPEN: begin
                        if (!door_any_c) begin
                            state_q    <= ST_SOUND_CLOSED;
                            interval_q <= SEL_ALARM;
                            start_q    <= 1'b1;
                        end
                    end
                    ST_SOUND_CLOSED: begin
                        if (door_any_c) begin
                            state_q <= ST_SOUND_OPEN;
                        end else if (exp_c) begin
                            state_q  <= ST_ARMED;
                            siren_q  <= 1'b0;
                            status_q <= 1'b0;
                        end
                    end
                    ST_DISARMED: begin
                        state_q <= ST_WAIT_OPEN;
                    end
                    ST_WAIT_OPEN: begin
                        if (door_driver) begin
                            state_q <= ST_WAIT_CLOSE;
                        end
                    end
                    ST_WAIT_CLOSE: begin
                        if (!rearm_block_c) begin
                            state_q    <= ST_ARM_DELAY;
                            interval_q <= SEL_ARM;
                            start_q    <= 1'b1;
                        end
                    end
                    ST_ARM_DELAY: begin
                        if (rearm_block_c) begin
                            state_q <= ST_WAIT_CLOSE;
                        end else if (exp_c) begin
                            state_q  <= ST_ARMED;
                            status_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_ARMED;
                    end
                endcase
            end
        end
    end

    assign interval     = interval_q;
    assign start_timer  = start_q;
    assign enable_siren = siren_q;
    assign status       = status_q;
    assign state_code   = state_q;

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Scoreboard bench for alarm_ctrl_fsm: directed scenarios plus randomized traffic
// against a behavioural model of the alarm rules.
module tb_alarm_ctrl_fsm;

    localparam int C_ARMED = 0, C_TRIG = 1, C_SND_OPEN = 2, C_SND_CLOSED = 3;
    localparam int C_DISARMED = 4, C_WAIT_OPEN = 5, C_WAIT_CLOSE = 6, C_ARM_DELAY = 7;
`ifdef REARM_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ignition = 1'b0;
    logic       door_driver = 1'b0;
    logic       door_pass = 1'b0;
    logic       reprogram = 1'b0;
    logic       expired = 1'b0;
    logic       one_hz_enable = 1'b0;
    logic [1:0] interval;
    logic       start_timer;
    logic       enable_siren;
    logic       status;
    logic [2:0] state_code;

    always #5 clk = ~clk;

    alarm_ctrl_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .ignition      (ignition),
        .door_driver   (door_driver),
        .door_pass     (door_pass),
        .reprogram     (reprogram),
        .expired       (expired),
        .one_hz_enable (one_hz_enable),
        .interval      (interval),
        .start_timer   (start_timer),
        .enable_siren  (enable_siren),
        .status        (status),
        .state_code    (state_code)
    );

    typedef struct packed {
        logic [2:0] code;
        logic [1:0] intv;
        logic       start;
        logic       siren;
        logic       led;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: alarm situation, last programmed interval, and age of the current countdown.
    int         m_state  = C_ARMED;
    logic [1:0] m_int    = 2'b00;
    logic       m_start  = 1'b0;
    logic       m_siren  = 1'b0;
    logic       m_status = 1'b0;
    bit         m_owned  = 1'b0;
    int         m_age    = 99;

    task automatic model_step();
        bit         doors;
        bit         fired;
        bit         st;
        int         ns;
        logic [1:0] ni;
        if (reset) begin
            m_state = C_ARMED; m_int = 2'b00; m_start = 1'b0;
            m_siren = 1'b0; m_status = 1'b0; m_owned = 1'b0; m_age = 99;
            return;
        end
        doors = door_driver || door_pass;
        fired = m_owned && (m_age >= 2) && expired;
        ns = m_state; st = 1'b0; ni = m_int;
        if (reprogram) ns = C_ARMED;
        else if (ignition) ns = C_DISARMED;
        else begin
            case (m_state)
                C_ARMED:
                    if (door_driver)    begin ns = C_TRIG; st = 1'b1; ni = 2'b01; end
                    else if (door_pass) begin ns = C_TRIG; st = 1'b1; ni = 2'b10; end
                C_TRIG:
                    if (fired) begin
                        if (doors) ns = C_SND_OPEN;
                        else begin ns = C_SND_CLOSED; st = 1'b1; ni = 2'b11; end
                    end
                C_SND_OPEN:
                    if (!doors) begin ns = C_SND_CLOSED; st = 1'b1; ni = 2'b11; end
                C_SND_CLOSED:
                    if (doors) ns = C_SND_OPEN;
                    else if (fired) ns = C_ARMED;
                C_DISARMED:  ns = C_WAIT_OPEN;
                C_WAIT_OPEN: if (door_driver) ns = C_WAIT_CLOSE;
                C_WAIT_CLOSE:
                    if (!door_driver && !(ABORT && door_pass)) begin
                        ns = C_ARM_DELAY; st = 1'b1; ni = 2'b00;
                    end
                C_ARM_DELAY:
                    if (door_driver || (ABORT && door_pass)) ns = C_WAIT_CLOSE;
                    else if (fired) ns = C_ARMED;
                default: ns = C_ARMED;
            endcase
        end
        if (ns == C_ARMED) m_status = (m_state == C_ARMED) ? (m_status ^ one_hz_enable) : 1'b0;
        else               m_status = (ns >= C_TRIG && ns <= C_SND_CLOSED);
        m_siren = (ns == C_SND_OPEN) || (ns == C_SND_CLOSED);
        if (st) begin
            m_owned = 1'b1; m_age = 0;
        end else begin
            if (ns != m_state) m_owned = 1'b0;
            if (m_age < 99) m_age++;
        end
        m_state = ns; m_int = ni; m_start = st;
    endtask

    task automatic drive(input bit rst, input bit ign, input bit dd, input bit dp,
                         input bit rp, input bit ex, input bit hz);
        exp_t e;
        @(negedge clk);
        reset = rst; ignition = ign; door_driver = dd; door_pass = dp;
        reprogram = rp; expired = ex; one_hz_enable = hz;
        model_step();
        e.code = 3'(m_state); e.intv = m_int; e.start = m_start;
        e.siren = m_siren; e.led = m_status;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set.
    logic prev_start = 1'b0;
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a.code = state_code; a.intv = interval; a.start = start_timer;
                a.siren = enable_siren; a.led = status;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual code=%0d intv=%0d start=%0b siren=%0b status=%0b required code=%0d intv=%0d start=%0b siren=%0b status=%0b",
                             $time, a.code, a.intv, a.start, a.siren, a.led,
                             e.code, e.intv, e.start, e.siren, e.led);
                end
                n_checks++;
                if (start_timer && prev_start) begin
                    n_fail++;
                    $display("FAIL start_back_to_back t=%0t actual 2 consecutive cycles required 1", $time);
                end
                prev_start = start_timer;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p_dd, p_dp, p_ign, p_rp, p_ex, p_hz;
        // Reset, then idle ARMED with six 1 Hz strobes.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0, 0, (i % 2) == 0);
        // Driver door trips the alarm while expired is stale-high; door stays open.
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, 1);
        // Owner path: ignition on/off, driver open/close, arming delay expires.
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0);
        // Passenger door trip into SOUND_OPEN, then reprogram and ignition together.
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        // Passenger door during the arming delay.
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, 0);
        // Randomized traffic under two input profiles.
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin p_dd = 15; p_dp = 15; p_ign = 4; p_rp = 2; p_ex = 50; p_hz = 25; end
            else           begin p_dd = 35; p_dp = 25; p_ign = 10; p_rp = 1; p_ex = 70; p_hz = 50; end
            for (int i = 0; i < 1500; i++) begin
                drive($urandom_range(999) < 3,
                      $urandom_range(99) < p_ign, $urandom_range(99) < p_dd,
                      $urandom_range(99) < p_dp,  $urandom_range(99) < p_rp,
                      $urandom_range(99) < p_ex,  $urandom_range(99) < p_hz);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
